// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of the shared combinational program/data ROM.
// IF and LD each get a req/gnt/rvalid handshake; one access per two cycles.
module rom_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_LD_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_byte_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_misalign,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LD_STREAK);

    state_t      state, state_next;
    logic [3:0]  ld_streak, streak_next;
    logic        ld_win, if_win;
    logic        owner_ld;
    logic        mis_pending;

    // LD normally wins; once it has taken STREAK_MAX grants in a row while IF
    // waited, IF gets the next slot.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_next  = state;
        ld_win      = 1'b0;
        if_win      = 1'b0;
        streak_next = ld_streak;
        case (state)
            IDLE: begin
                if (ld_req && !(if_req && ld_streak == STREAK_MAX)) begin
                    ld_win     = 1'b1;
                    state_next = ACCESS;
                    if (!if_req)
                        streak_next = '0;
                    else if (ld_streak != STREAK_MAX)
                        streak_next = ld_streak + 4'd1;
                end else if (if_req) begin
                    if_win      = 1'b1;
                    streak_next = '0;
                    state_next  = ACCESS;
                end
            end
            ACCESS: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_streak   <= '0;
            if_gnt      <= 1'b0;
            ld_gnt      <= 1'b0;
            if_rvalid   <= 1'b0;
            ld_rvalid   <= 1'b0;
            if_rdata    <= '0;
            ld_rdata    <= '0;
            ld_misalign <= 1'b0;
            rom_addr    <= '0;
            owner_ld    <= 1'b0;
            mis_pending <= 1'b0;
        end else begin
            ld_streak <= streak_next;
            if_gnt    <= if_win;
            ld_gnt    <= ld_win;
            if_rvalid <= 1'b0;
            ld_rvalid <= 1'b0;
            if (ld_win) begin
                rom_addr    <= {2'b00, ld_byte_addr[ADDR_W-1:2]};
                owner_ld    <= 1'b1;
                mis_pending <= |ld_byte_addr[1:0];
            end else if (if_win) begin
                rom_addr <= if_addr;
                owner_ld <= 1'b0;
            end
            // The ROM is combinational, so data for rom_addr is ready in ACCESS.
            if (state == ACCESS) begin
                if (owner_ld) begin
                    ld_rvalid   <= 1'b1;
                    ld_rdata    <= rom_data;
                    ld_misalign <= mis_pending;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= rom_data;
                end
            end
        end
    end

    assign busy = (state == ACCESS);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed vector table plus
// sequences for streak fairness and reset during an access.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ld_req;
    logic [31:0] if_addr, ld_byte_addr;
    logic        if_gnt, if_rvalid, ld_gnt, ld_rvalid, ld_misalign, busy;
    logic [31:0] if_rdata, ld_rdata, rom_addr, rom_data;

    int n_cmp  = 0;
    int n_fail = 0;

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LD_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_byte_addr(ld_byte_addr), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_misalign(ld_misalign),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_model(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h8C01_007F;
            32'd1:   return 32'h2042_0001;
            32'd31:  return 32'h0003_0800;
            32'd32:  return 32'h89AB_CDEF;
            32'd33:  return 32'h0123_4567;
            32'd34:  return 32'h0F1E_2D3C;
            32'd35:  return 32'hDEAD_BEEF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    always_comb rom_data = rom_model(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ld_req;
        logic [31:0] ld_byte_addr;
        logic        exp_ld;
        logic [31:0] exp_rom_addr;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int i);
        vec_t v = vecs[i];
        @(negedge clk);
        if_req = v.if_req; if_addr = v.if_addr;
        ld_req = v.ld_req; ld_byte_addr = v.ld_byte_addr;
        @(posedge clk); #1;
        check($sformatf("v%0d ld_gnt", i), {31'd0, ld_gnt}, {31'd0, v.exp_ld});
        check($sformatf("v%0d if_gnt", i), {31'd0, if_gnt}, {31'd0, !v.exp_ld});
        check($sformatf("v%0d rom_addr", i), rom_addr, v.exp_rom_addr);
        check($sformatf("v%0d busy", i), {31'd0, busy}, 32'd1);
        if_req = 1'b0; ld_req = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d ld_rvalid", i), {31'd0, ld_rvalid}, {31'd0, v.exp_ld});
        check($sformatf("v%0d if_rvalid", i), {31'd0, if_rvalid}, {31'd0, !v.exp_ld});
        check($sformatf("v%0d busy_after", i), {31'd0, busy}, 32'd0);
        if (v.exp_ld) begin
            check($sformatf("v%0d ld_rdata", i), ld_rdata, v.exp_rdata);
            check($sformatf("v%0d ld_misalign", i), {31'd0, ld_misalign}, {31'd0, v.exp_mis});
        end else begin
            check($sformatf("v%0d if_rdata", i), if_rdata, v.exp_rdata);
        end
    endtask

    initial begin
        string exp_order = "LLLLILLLLI";
        string got_order = "";
        int    budget;

        //          if_req if_addr  ld_req ld_byte_addr  ld?   rom_addr     rdata          mis
        vecs[0] = '{1'b1, 32'h00,  1'b0, 32'h00,       1'b0, 32'h00,      32'h8C01_007F, 1'b0};
        vecs[1] = '{1'b0, 32'h00,  1'b1, 32'h7C,       1'b1, 32'h1F,      32'h0003_0800, 1'b0};
        vecs[2] = '{1'b0, 32'h00,  1'b1, 32'h80,       1'b1, 32'h20,      32'h89AB_CDEF, 1'b0};
        vecs[3] = '{1'b0, 32'h00,  1'b1, 32'h7E,       1'b1, 32'h1F,      32'h0003_0800, 1'b1};
        vecs[4] = '{1'b1, 32'h30,  1'b0, 32'h00,       1'b0, 32'h30,      32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{1'b1, 32'h00,  1'b1, 32'h84,       1'b1, 32'h21,      32'h0123_4567, 1'b0};
        vecs[6] = '{1'b0, 32'h00,  1'b1, 32'hFFFF_FFFF, 1'b1, 32'h3FFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{1'b1, 32'h23,  1'b0, 32'h00,       1'b0, 32'h23,      32'hDEAD_BEEF, 1'b0};

        rst = 1'b1; if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_byte_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {if_gnt, if_rvalid, ld_gnt, ld_rvalid, ld_misalign, busy}, 6'd0);
        check("reset rom_addr", rom_addr, 32'd0);
        check("reset if_rdata", if_rdata, 32'd0);
        check("reset ld_rdata", ld_rdata, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
            if (i == 0) begin
                check("ld_rdata untouched by fetch", ld_rdata, 32'd0);
                check("ld_misalign untouched by fetch", {31'd0, ld_misalign}, 32'd0);
            end
        end

        // Idle with no request: rom_addr holds.
        @(posedge clk); #1;
        check("idle rom_addr hold", rom_addr, 32'h23);
        check("idle busy", {31'd0, busy}, 32'd0);

        // Both requesters held continuously: LD streak capped at 4.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h1; ld_req = 1'b1; ld_byte_addr = 32'h88;
        budget = 0;
        while (got_order.len() < 10 && budget < 40) begin
            @(posedge clk); #1;
            budget++;
            check("single gnt", {31'd0, if_gnt & ld_gnt}, 32'd0);
            check("single rvalid", {31'd0, if_rvalid & ld_rvalid}, 32'd0);
            if (ld_gnt) got_order = {got_order, "L"};
            if (if_gnt) got_order = {got_order, "I"};
        end
        if_req = 1'b0; ld_req = 1'b0;
        n_cmp++;
        if (got_order != exp_order) begin
            n_fail++;
            $display("FAIL grant order: got %s, expected %s", got_order, exp_order);
        end
        @(posedge clk); #1;
        check("streak last if_rdata", if_rdata, 32'h2042_0001);
        @(posedge clk);

        // Reset asserted during the ACCESS cycle of a load; IF held throughout.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0; ld_req = 1'b1; ld_byte_addr = 32'h7C;
        @(posedge clk); #1;
        check("rst-seq ld_gnt", {31'd0, ld_gnt}, 32'd1);
        ld_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst-seq ld_rvalid", {31'd0, ld_rvalid}, 32'd0);
        check("rst-seq ld_rdata", ld_rdata, 32'd0);
        check("rst-seq busy", {31'd0, busy}, 32'd0);
        check("rst-seq if_gnt during rst", {31'd0, if_gnt}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rst-seq if_gnt after rst", {31'd0, if_gnt}, 32'd1);
        check("rst-seq rom_addr", rom_addr, 32'h0);
        if_req = 1'b0;
        @(posedge clk); #1;
        check("rst-seq if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check("rst-seq if_rdata", if_rdata, 32'h8C01_007F);
        check("rst-seq no ld_rvalid", {31'd0, ld_rvalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational program/data ROM between two requesters: the MIPS instruction-fetch unit (IF) and the load unit (LD).
- Each requester uses a req/gnt/rvalid handshake.
- The block drives a registered word address into the ROM and returns registered read data.
- It sits between the core's fetch/load stages and the ROM. It replaces direct ROM wiring, so loads of constants (e.g. DES data/key words at M[31..35]) no longer collide with fetch.

Parameters:
- ADDR_W, 32, width of ROM word address and requester addresses
- DATA_W, 32, ROM data width
- MAX_LD_STREAK, 4, maximum consecutive LD grants while IF is pending; range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  one-cycle grant pulse to IF
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetch data
- ld_req  in  1  load request; held with ld_byte_addr until ld_gnt
- ld_byte_addr  in  ADDR_W  load byte address (base+offset)
- ld_gnt  out  1  one-cycle grant pulse to LD
- ld_rvalid  out  1  one-cycle pulse; ld_rdata and ld_misalign valid
- ld_rdata  out  DATA_W  load data
- ld_misalign  out  1  byte address had bits [1:0] != 0
- rom_addr  out  ADDR_W  registered word address to ROM
- rom_data  in  DATA_W  ROM combinational read data
- busy  out  1  high in ACCESS state

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On rst, all outputs are 0: gnt, rvalid, rdata, ld_misalign, rom_addr, busy. The streak counter is 0 and the FSM enters IDLE.
- Reset mid-ACCESS: the pending rvalid is suppressed, and no grant is remembered after reset.
- FSM states: IDLE and ACCESS.
- IDLE with no req: stay IDLE; rom_addr holds its last value.
- IDLE with any req: select a winner, register rom_addr, pulse the winner's gnt, record the owner, and go to ACCESS next cycle.
  - LD winner: rom_addr <= ld_byte_addr >> 2, with zero fill in the top 2 bits. The misalign flag is latched as |ld_byte_addr[1:0].
  - IF winner: rom_addr <= if_addr.
- ACCESS: capture rom_data into the owner's rdata and pulse the owner's rvalid (next cycle), then return to IDLE. Requests are ignored in ACCESS.
- Latency and throughput:
  - req sampled high in IDLE at edge N.
  - gnt high during cycle N..N+1.
  - rvalid and rdata valid during cycle N+1..N+2.
  - Throughput is 1 access per 2 cycles.
- Handshake: a requester must drop req in the gnt cycle unless it wants another access. req high when the FSM next samples in IDLE counts as a new request.
- rdata registers hold their value until that port's next rvalid. ld_misalign updates only with ld_rvalid.
- Arbitration: LD has priority over IF, except when ld_streak == MAX_LD_STREAK and if_req is high, in which case IF wins.
- Streak counter:
  - LD grant: ld_streak increments, saturating at MAX_LD_STREAK.
  - IF grant: ld_streak clears to 0.
  - LD grant with if_req low: ld_streak also clears to 0 (IF not starved).
- Out-of-range addresses are passed through unchecked. The ROM default 0xFFFFFFFF is returned as data.
- gnt pulses are never high simultaneously, and rvalid pulses are never high simultaneously.
- busy == (state == ACCESS).

Test Plan:
- Reset then if_req=1, if_addr=0x0 -> if_gnt at cycle 1, if_rvalid at cycle 2, if_rdata=0x8C01007F; ld outputs stay 0.
- ld_req=1, ld_byte_addr=0x7C -> rom_addr=0x1F, ld_rdata=0x00030800, ld_misalign=0. Then ld_byte_addr=0x80 -> ld_rdata=0x89ABCDEF.
- ld_byte_addr=0x7E -> rom_addr=0x1F, ld_rdata=0x00030800, ld_misalign=1 with ld_rvalid.
- if_addr=0x30 (unmapped) -> if_rdata=0xFFFFFFFF.
- if_req and ld_req both held continuously, MAX_LD_STREAK=4 -> grant order LD,LD,LD,LD,IF,LD,LD,LD,LD,IF; never two gnt or two rvalid in the same cycle.
- rst asserted in the ACCESS cycle of an LD read -> no ld_rvalid, ld_rdata=0, next cycle IDLE. A held if_req is granted 1 cycle after rst drops.
